// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential divider: FSM state encoding, state
// register width and the default operand widths used by seq_divider.
// -----------------------------------------------------------------------------
package divider_pkg;

  // Width of the divider FSM state register.
  localparam int STATE_W = 2;

  // Default dividend/quotient width (N) and divisor/remainder width (M).
  localparam int DEFAULT_DIVIDEND_W = 16;
  localparam int DEFAULT_DIVISOR_W  = 8;

  // IDLE waits for req, RUN performs N iterations, FINALISE publishes results.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FINALISE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational non-restoring division iteration.
//
// Ports:
//   p_i    [M:0]   partial remainder (two's complement, MSB is the sign)
//   bit_i          next dividend bit shifted into the partial remainder
//   d_i    [M-1:0] divisor magnitude
//   p_o    [M:0]   new partial remainder
//   q_o            new quotient bit (inverted sign of p_o)
//
// The shifted value 2*p+bit can exceed M+1 signed bits, but the result of the
// add/subtract always lies in [-d, d), so wrapping arithmetic in M+1 bits
// yields the exact partial remainder.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int M = 8
) (
  input  logic [M:0]   p_i,
  input  logic         bit_i,
  input  logic [M-1:0] d_i,
  output logic [M:0]   p_o,
  output logic         q_o
);

  logic [M:0] shifted_s;
  logic [M:0] d_ext_s;

  assign shifted_s = {p_i[M-1:0], bit_i};
  assign d_ext_s   = {1'b0, d_i};

  // Negative partial remainder restores by adding, otherwise subtract.
  always_comb begin
    p_o = shifted_s;
    if (p_i[M]) begin
      p_o = shifted_s + d_ext_s;
    end else begin
      p_o = shifted_s - d_ext_s;
    end
  end

  assign q_o = ~p_o[M];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential non-restoring divider, N-bit dividend / M-bit divisor, with a
// req/ack handshake. Latency from the accept edge to ack is N+1 cycles, or
// 1 cycle for divide-by-zero. All outputs are registered.
//
// Build option: define DIVIDER_SIGNED_EN to add the signed_op input and
// two's complement division (truncation toward zero, remainder carries the
// dividend's sign). Without it the divider is unsigned only.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req          start request, sampled only in IDLE
//   dividend     [N-1:0] captured on accepted req
//   divisor      [M-1:0] captured on accepted req
//   signed_op    (DIVIDER_SIGNED_EN only) captured on accepted req
//   busy         high from accept edge until ack edge
//   ack          one-cycle pulse, results valid from this cycle
//   quotient     [N-1:0] result, held until next ack
//   remainder    [M-1:0] result, held until next ack
//   div_by_zero  divide-by-zero flag for the last result
// -----------------------------------------------------------------------------
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
  parameter int DIVISOR_W  = DEFAULT_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic                  signed_op,
`endif
  output logic                  busy,
  output logic                  ack,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int N     = DIVIDEND_W;
  localparam int M     = DIVISOR_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_e         state_q, state_d;
  logic [M:0]     p_q, p_d;       // partial remainder
  logic [N-1:0]   q_q, q_d;       // dividend bits out of the MSB, quotient bits in at the LSB
  logic [M-1:0]   d_q, d_d;       // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           ack_q, ack_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   dividend_mag_s;
  logic [M-1:0]   divisor_mag_s;
  logic [M:0]     step_p_s;
  logic           step_q_s;
  logic [M-1:0]   rem_raw_s;
  logic [N-1:0]   quot_res_s;
  logic [M-1:0]   rem_res_s;

  div_step #(.M(M)) u_step (
    .p_i   (p_q),
    .bit_i (q_q[N-1]),
    .d_i   (d_q),
    .p_o   (step_p_s),
    .q_o   (step_q_s)
  );

  // Final remainder correction; M-bit wrap is exact since the result is in [0, d).
  always_comb begin
    rem_raw_s = p_q[M-1:0];
    if (p_q[M]) begin
      rem_raw_s = p_q[M-1:0] + d_q;
    end else begin
      rem_raw_s = p_q[M-1:0];
    end
  end

`ifdef DIVIDER_SIGNED_EN
  logic a_neg_s, b_neg_s;
  logic neg_q_q, neg_q_d;   // negate quotient in FINALISE
  logic neg_r_q, neg_r_d;   // negate remainder in FINALISE

  assign a_neg_s = signed_op & dividend[N-1];
  assign b_neg_s = signed_op & divisor[M-1];

  // Operand magnitudes; the most-negative value maps onto itself as unsigned.
  always_comb begin
    dividend_mag_s = dividend;
    divisor_mag_s  = divisor;
    if (a_neg_s) begin
      dividend_mag_s = -dividend;
    end else begin
      dividend_mag_s = dividend;
    end
    if (b_neg_s) begin
      divisor_mag_s = -divisor;
    end else begin
      divisor_mag_s = divisor;
    end
  end

  // Capture the result sign fixes together with the operands.
  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if ((state_q == IDLE) && req) begin
      neg_q_d = a_neg_s ^ b_neg_s;
      neg_r_d = a_neg_s;
    end else begin
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
    end
  end

  // Sign-fix flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  assign quot_res_s = neg_q_q ? -q_q : q_q;
  assign rem_res_s  = neg_r_q ? -rem_raw_s : rem_raw_s;
`else
  assign dividend_mag_s = dividend;
  assign divisor_mag_s  = divisor;
  assign quot_res_s     = q_q;
  assign rem_res_s      = rem_raw_s;
`endif

  // Next-state and datapath/output update logic.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          p_d    = '0;
          q_d    = dividend_mag_s;
          d_d    = divisor_mag_s;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = FINALISE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = step_p_s;
        q_d   = {q_q[N-2:0], step_q_s};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FINALISE;
        end else begin
          state_d = RUN;
        end
      end
      FINALISE: begin
        busy_d  = 1'b0;
        ack_d   = 1'b1;
        state_d = IDLE;
        // A zero divisor magnitude means the captured divisor was zero.
        if (d_q == '0) begin
          quot_d = '1;
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          quot_d = quot_res_s;
          rem_d  = rem_res_s;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign ack         = ack_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed, table-driven bench for seq_divider (N=16, M=8) with hand-written
// sequences for continuous req, operand changes while busy and mid-operation
// reset. Signed vectors are included when DIVIDER_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        signed_op;
  logic        busy;
  logic        ack;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks;
  int errors;

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .ack         (ack),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          elat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, return cycles from the accept edge to ack (-1 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic s, output int lat);
    @(negedge clk);
    req = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int c1;
    int c2;
    logic seen_ack;
    checks = 0; errors = 0;
    req = 1'b0; dividend = 16'd0; divisor = 8'd0; signed_op = 1'b0;
    reset_n = 1'b0;

    vecs.push_back('{16'd200,   8'd7,   1'b0, 16'd28,     8'd4,    1'b0, 17});
    vecs.push_back('{16'hFFFF,  8'd1,   1'b0, 16'hFFFF,   8'd0,    1'b0, 17});
    vecs.push_back('{16'd5,     8'd9,   1'b0, 16'd0,      8'd5,    1'b0, 17});
    vecs.push_back('{16'd1234,  8'd0,   1'b0, 16'hFFFF,   8'd0,    1'b1, 1});
    vecs.push_back('{16'd10,    8'd3,   1'b0, 16'd3,      8'd1,    1'b0, 17});
    vecs.push_back('{16'd0,     8'd5,   1'b0, 16'd0,      8'd0,    1'b0, 17});
    vecs.push_back('{16'd255,   8'd255, 1'b0, 16'd1,      8'd0,    1'b0, 17});
    vecs.push_back('{16'hFFFF,  8'd255, 1'b0, 16'd257,    8'd0,    1'b0, 17});
    vecs.push_back('{16'd1000,  8'd33,  1'b0, 16'd30,     8'd10,   1'b0, 17});
    vecs.push_back('{16'd40000, 8'd200, 1'b0, 16'd200,    8'd0,    1'b0, 17});
    vecs.push_back('{16'd12345, 8'd128, 1'b0, 16'd96,     8'd57,   1'b0, 17});
    vecs.push_back('{16'hFF9C,  8'd7,   1'b0, 16'h2484,   8'd0,    1'b0, 17});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{16'hFF9C,  8'h07,  1'b1, 16'hFFF2,   8'hFE,   1'b0, 17});
    vecs.push_back('{16'h0064,  8'hF9,  1'b1, 16'hFFF2,   8'h02,   1'b0, 17});
    vecs.push_back('{16'h8000,  8'hFF,  1'b1, 16'h8000,   8'h00,   1'b0, 17});
    vecs.push_back('{16'd1234,  8'd0,   1'b1, 16'hFFFF,   8'd0,    1'b1, 1});
`endif

    // Reset state
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_quotient", {16'd0, quotient}, 32'd0);
    chk("reset_remainder", {24'd0, remainder}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_quotient", i), {16'd0, quotient}, {16'd0, vecs[i].eq});
      chk($sformatf("v%0d_remainder", i), {24'd0, remainder}, {24'd0, vecs[i].er});
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].ez});
      chk($sformatf("v%0d_busy_at_ack", i), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ack_pulse", i), {31'd0, ack}, 32'd0);
      chk($sformatf("v%0d_hold_q", i), {16'd0, quotient}, {16'd0, vecs[i].eq});
    end

    // req held high: operands change while busy, accepts every 18 cycles
    @(negedge clk);
    req = 1'b1; dividend = 16'd200; divisor = 8'd7; signed_op = 1'b0;
    @(posedge clk);
    #1;
    c1 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        dividend = 16'd10; divisor = 8'd3;
      end
      if (ack) begin
        c1 = c;
        break;
      end
    end
    chk("cont_first_latency", c1, 17);
    chk("cont_first_quotient", {16'd0, quotient}, 32'd28);
    chk("cont_first_remainder", {24'd0, remainder}, 32'd4);
    c2 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        c2 = c;
        break;
      end
    end
    req = 1'b0;
    chk("cont_ack_interval", c2, 18);
    chk("cont_second_quotient", {16'd0, quotient}, 32'd3);
    chk("cont_second_remainder", {24'd0, remainder}, 32'd1);
    repeat (2) @(posedge clk);

    // Reset 5 cycles after accept aborts the operation
    @(negedge clk);
    req = 1'b1; dividend = 16'd200; divisor = 8'd7;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_ack = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (ack) seen_ack = 1'b1;
    end
    chk("abort_no_ack", {31'd0, seen_ack}, 32'd0);
    run_op(16'd1000, 8'd33, 1'b0, lat);
    chk("after_abort_latency", lat, 17);
    chk("after_abort_quotient", {16'd0, quotient}, 32'd30);
    chk("after_abort_remainder", {24'd0, remainder}, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential non-restoring divider with independent dividend and divisor widths. Uses a req/ack handshake, reports divide-by-zero, and returns the result after a fixed, width-dependent latency. Serves the scandoubler and video timing logic wherever a ratio is needed without a combinational divider. Signed operation is an optional build feature.

## Interface
- `DIVIDEND_W`, 16: dividend and quotient width (N), ≥2.
- `DIVISOR_W`, 8: divisor and remainder width (M), ≥2, ≤ N.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req`  in  1  start request, sampled only in IDLE.
- `dividend`  in  N  captured on accepted req.
- `divisor`  in  M  captured on accepted req.
- `signed_op`  in  1  only present with `DIVIDER_SIGNED_EN`; captured on accepted req.
- `busy`  out  1  high from accept edge until ack edge.
- `ack`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  N  result, held until next ack.
- `remainder`  out  M  result, held until next ack.
- `div_by_zero`  out  1  flag for the last result, held until next ack.

## Operation
- States:
  - IDLE: on req, capture operands and go to RUN, or to FINALISE if divisor==0.
  - RUN: N iterations, then FINALISE.
  - FINALISE: write results, pulse ack, return to IDLE.
- Partial remainder is M+1 bits (MSB is sign). Each RUN step:
  - Shift in quotient MSB.
  - Add divisor if the partial remainder is negative, else subtract it.
  - New quotient LSB = inverted sign.
- FINALISE corrects the remainder by adding the divisor if it is negative. `quotient` and `remainder` are registered.
- Divide by zero:
  - `quotient` = all ones, `remainder` = 0, `div_by_zero` = 1.
  - No RUN cycles.
- Otherwise `div_by_zero` = 0. Dividend < divisor gives quotient 0, remainder = dividend.
- `req` is ignored while `busy`. `req` high in the ack cycle is accepted at the next edge, since the state is already IDLE.
- Reset, including mid-operation, drives all outputs to 0 and the state to IDLE. No ack is issued for the aborted operation.

## Timing
- Accept at edge T. RUN occupies edges T+1..T+N. FINALISE at edge T+N+1 raises ack and updates the results.
- Latency from accept edge to ack: N+1 cycles. Divide-by-zero: 1 cycle.
- Back-to-back throughput: one result per N+2 cycles.
- `busy` rises at T and falls at T+N+1, in the same edge that ack rises.

## Configuration
- `DIVIDER_SIGNED_EN` defined:
  - Adds the `signed_op` input.
  - When `signed_op` is captured as 1, operands are two's complement. Magnitudes are divided.
  - Quotient is negated when the operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - Sign fix is applied in FINALISE with no extra cycle.
  - Most-negative dividend / −1 wraps to the most-negative value, with no flag.
  - Divide by zero gives the same output as unsigned.
- Undefined: no `signed_op` port; unsigned only. Behaviour is identical to `signed_op`=0.

## Structure
- `divider_pkg`: state enum (IDLE, RUN, FINALISE), state width, default width localparams.
- Sub-module `div_step`: combinational single non-restoring iteration. It takes the partial remainder, next dividend bit and divisor, and returns the new partial remainder and quotient bit. It is parameterised on M.
- Iteration counter width is $clog2(N).

## Test plan
- N=16, M=8: 200/7 → quotient 28, remainder 4, div_by_zero 0; ack exactly 17 cycles after the accept edge.
- 65535/1 → quotient 0xFFFF, remainder 0. 5/9 → quotient 0, remainder 5.
- 1234/0 → ack 1 cycle after accept; quotient 0xFFFF, remainder 0, div_by_zero 1. A following 10/3 → quotient 3, remainder 1, div_by_zero 0.
- `req` held high continuously → operations accepted every 18 cycles. Changing operands while busy has no effect on the current result.
- Assert reset_n low 5 cycles after accept → all outputs 0 immediately, no ack. A new req after release completes normally.
- With `DIVIDER_SIGNED_EN`, `signed_op`=1:
  - −100/7 → quotient 0xFFF2 (−14), remainder 0xFE (−2).
  - 100/−7 → quotient −14, remainder 2.
  - 0x8000/−1 → quotient 0x8000.
